// File: rtl/multi_add_pipe.sv
// multi_add_pipe: pipelined pairwise adder tree over NUM_OPS operands plus
// a carry-in.
//
// Parameters:
//   WIDTH   operand and sum width (>= 2)
//   NUM_OPS operand count, power of two, 2..32
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake; in_ready = !stall
//   ops                  packed operands, operand k at [k*WIDTH +: WIDTH]
//   ci                   carry-in, adds +1 to the total
//   out_valid/out_ready  output handshake
//   s                    low WIDTH bits of the total (or saturated)
//   co                   set when total >= 2^WIDTH
//
// Build option:
//   MULTI_ADD_PIPE_SAT_EN  when defined, s saturates to all ones on co.
//
// The tree is a heap: node 1 is the root, node i has children 2i and
// 2i+1, and indices NUM_OPS..2*NUM_OPS-1 are the operands themselves.
// Every internal node is a register, so depth d lives in stage LVLS-d.
// All nodes carry WIDTH+LVLS bits, so no partial sum can ever overflow.

module multi_add_pipe #(
   parameter int WIDTH   = 7,
   parameter int NUM_OPS = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_OPS*WIDTH-1:0] ops,
   input  logic                     ci,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         s,
   output logic                     co
);

   localparam int LVLS = $clog2(NUM_OPS);
   localparam int TW   = WIDTH + LVLS;

   logic [TW-1:0] leaf   [NUM_OPS];
   logic [TW-1:0] node_d [1:NUM_OPS-1];
   logic [TW-1:0] node_q [1:NUM_OPS-1];
   logic [LVLS:1] vld;
   logic          stall;
   logic [TW-1:0] total;

   for (genvar k = 0; k < NUM_OPS; k++) begin : g_leaf
      assign leaf[k] = TW'(ops[k*WIDTH +: WIDTH]);
   end

   // Stage-1 nodes add two operands; node NUM_OPS/2 also takes ci.
   // Worst case there is 2*(2^W-1)+1, which still fits in W+1 bits.
   for (genvar i = 1; i < NUM_OPS; i++) begin : g_node
      if (2*i >= NUM_OPS) begin : g_s1
         if (i == NUM_OPS/2) begin : g_ci
            assign node_d[i] = leaf[2*i-NUM_OPS]
                             + leaf[2*i-NUM_OPS+1]
                             + TW'(ci);
         end else begin : g_pair
            assign node_d[i] = leaf[2*i-NUM_OPS]
                             + leaf[2*i-NUM_OPS+1];
         end
      end else begin : g_up
         assign node_d[i] = node_q[2*i] + node_q[2*i+1];
      end
   end

   // The whole tree moves as one: bubbles advance with their
   // don't-care data, and everything freezes on a stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         for (int i = 1; i < NUM_OPS; i++) begin
            node_q[i] <= '0;
         end
      end else if (!stall) begin
         vld[1] <= in_valid;
         for (int j = 2; j <= LVLS; j++) begin
            vld[j] <= vld[j-1];
         end
         for (int i = 1; i < NUM_OPS; i++) begin
            node_q[i] <= node_d[i];
         end
      end
   end

   assign out_valid = vld[LVLS];
   assign stall     = vld[LVLS] & ~out_ready;
   assign in_ready  = ~stall;
   assign total     = node_q[1];
   assign co        = |total[TW-1:WIDTH];

`ifdef MULTI_ADD_PIPE_SAT_EN
   assign s = co ? '1 : total[WIDTH-1:0];
`else
   assign s = total[WIDTH-1:0];
`endif

endmodule

// File: doc/multi_add_pipe.md
MULTI_ADD_PIPE -- requirements
Module: multi_add_pipe

Interface
REQ-001 Parameter WIDTH, 7, operand and sum bit width (>=2) SHALL be supported.
REQ-002 Parameter NUM_OPS, 8, operand count, power of two, 2..32, SHALL be supported.
REQ-003 Derived constant LVLS = log2(NUM_OPS), the adder-tree depth, SHALL be used throughout.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operand set and ci present this cycle.
REQ-007 in_ready  output  1  block accepts an operand set this cycle.
REQ-008 ops  input  NUM_OPS*WIDTH  packed operands; operand k at bits [k*WIDTH +: WIDTH].
REQ-009 ci  input  1  carry-in, added as +1 to the total.
REQ-010 out_valid  output  1  s/co hold a valid result.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 s  output  WIDTH  low WIDTH bits of result (see REQ-024).
REQ-013 co  output  1  overflow flag: total >= 2^WIDTH.

Function
REQ-014 Total SHALL be ci + sum of all NUM_OPS operands, unsigned, computed at WIDTH+LVLS bits with no internal loss.
REQ-015 Datapath SHALL be a pipelined pairwise tree of LVLS register stages; stage j adds pairs from stage j-1; ci SHALL be added in stage 1.
REQ-016 Each stage SHALL carry a valid bit; latency from accepted input to out_valid SHALL be exactly LVLS cycles with no stall.
REQ-017 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready at a rising edge.
REQ-018 stall = out_valid && !out_ready; when stall, every stage register and valid bit SHALL hold.
REQ-019 in_ready SHALL equal !stall (combinational); bubbles SHALL advance when not stalled.
REQ-020 While stalled, s, co and out_valid SHALL remain stable.
REQ-021 Throughput SHALL be one operand set per cycle while out_ready is held high.
REQ-022 in_valid low at an accepting edge SHALL insert a bubble (valid bit 0); data of bubble stages is don't-care.
REQ-023 co SHALL be the OR of total bits [WIDTH+LVLS-1:WIDTH].
REQ-024 s SHALL be total[WIDTH-1:0] (wrap) unless REQ-031 applies.
REQ-025 Inputs SHALL be sampled only on accepting edges; ops/ci changes at other times SHALL have no effect.

Reset
REQ-026 rst_n low SHALL immediately clear all stage valid bits; out_valid = 0, s = 0, co = 0.
REQ-027 in_ready SHALL be 1 during and after reset (out_valid = 0 implies no stall).
REQ-028 Reset mid-operation SHALL discard all in-flight results; none SHALL emerge after release.
REQ-029 First acceptance SHALL be possible at the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro MULTI_ADD_PIPE_SAT_EN SHALL select output saturation.
REQ-031 Defined: when co = 1, s SHALL be all ones (2^WIDTH-1); co still asserted.
REQ-032 Undefined: s SHALL wrap per REQ-024; co unchanged.

Verification
REQ-033 Defaults, ops all 1, ci=0 -> after 3 cycles s=8, co=0; ops 1..8 (op0=1), ci=1 -> s=37, co=0.
REQ-034 ops all 15, ci=0 -> s=120, co=0; op0=16, rest 15, ci=1 -> s=122, co=0.
REQ-035 ops 16 x7 + 15, ci=1 (total 128) -> co=1; s=0 without SAT_EN, s=127 with MULTI_ADD_PIPE_SAT_EN.
REQ-036 Back-to-back 5 sets with out_ready=1 -> 5 consecutive out_valid cycles, in order; then out_ready=0 for 4 cycles -> in_ready=0, s/co held, no loss or duplication on release.
REQ-037 Assert rst_n=0 with 2 sets in flight -> out_valid=0, s=0, co=0 immediately; no stale result after release.
REQ-038 WIDTH=4, NUM_OPS=4, ops all 15, ci=1 (total 61) -> latency 2, s=13 wrap or 15 saturated, co=1.
